// File: rtl/softmax_norm_pkg.sv
// -----------------------------------------------------------------------------
// softmax_norm_pkg
// Shared widths, default sizes and the FSM state type for the softmax
// normalisation stage (softmax_norm, softmax_recip, softmax_norm_if).
// No ports; imported with `import softmax_norm_pkg::*;`.
// -----------------------------------------------------------------------------
package softmax_norm_pkg;

    localparam int LANES_DEF  = 16;  // parallel lanes
    localparam int N_DEF      = 16;  // beats per row (buffer depth)
    localparam int Y_W        = 8;   // y, Q1.7 unsigned
    localparam int MAX_W      = 30;  // running max, Q30.0 signed
    localparam int DEN_W      = 16;  // denominator, Q9.7 unsigned
    localparam int RECIP_W    = 17;  // reciprocal, Q1.16 unsigned
    localparam int P_W        = 8;   // probability, Q0.8 unsigned
    localparam int RECIP_ITER = 24;  // divider iterations = latency in cycles
    localparam int PROD_W     = Y_W + RECIP_W;  // yc * recip, Q2.23

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_RECIP = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/softmax_norm_if.sv
// -----------------------------------------------------------------------------
// softmax_norm_if
// Bundles the row input stream and the probability output handshake of
// softmax_norm.
//   i_y_valid, i_y, i_runmax, i_denom, i_denom_valid : row beats (producer)
//   o_p, o_valid, o_last                             : result stream (DUT)
//   i_ready                                          : downstream accept
// Modports: slave = softmax_norm side, master = producer/consumer side.
// -----------------------------------------------------------------------------
interface softmax_norm_if #(
    parameter int LANES = softmax_norm_pkg::LANES_DEF
) ();

    logic                                    i_y_valid;
    logic [softmax_norm_pkg::Y_W*LANES-1:0]   i_y;
    logic [softmax_norm_pkg::MAX_W*LANES-1:0] i_runmax;
    logic [softmax_norm_pkg::DEN_W*LANES-1:0] i_denom;
    logic                                    i_denom_valid;
    logic [softmax_norm_pkg::P_W*LANES-1:0]   o_p;
    logic                                    o_valid;
    logic                                    i_ready;
    logic                                    o_last;

    modport slave (
        input  i_y_valid, i_y, i_runmax, i_denom, i_denom_valid, i_ready,
        output o_p, o_valid, o_last
    );

    modport master (
        output i_y_valid, i_y, i_runmax, i_denom, i_denom_valid, i_ready,
        input  o_p, o_valid, o_last
    );

endinterface

// File: rtl/softmax_recip.sv
// -----------------------------------------------------------------------------
// softmax_recip
// Restoring divider computing recip = floor(2^23 / denom) as Q1.16 (17 bits).
// Denominators below 128 (including 0) return the saturated value 0x1FFFF.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : load i_denom and begin a division
//   i_denom        : Q9.7 unsigned denominator
//   o_recip        : result, valid from o_done onwards until the next start
//   o_done         : one-cycle pulse RECIP_ITER cycles after i_start
// -----------------------------------------------------------------------------
module softmax_recip
    import softmax_norm_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [DEN_W-1:0]   i_denom,
    output logic [RECIP_W-1:0] o_recip,
    output logic               o_done
);

    localparam int DVD_W = RECIP_ITER;
    localparam int CNT_W = $clog2(RECIP_ITER);

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DEN_W-1:0]   den_q, den_d;
    logic [DEN_W-1:0]   rem_q, rem_d;
    logic [DVD_W-1:0]   dvd_q, dvd_d;   // dividend bits shift out, quotient bits shift in
    logic               small_q, small_d;
    logic [RECIP_W-1:0] recip_q, recip_d;
    logic [DEN_W:0]     rem_sh;

    always_comb begin
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        den_d   = den_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        small_d = small_q;
        recip_d = recip_q;
        rem_sh  = {rem_q, dvd_q[DVD_W-1]};
        if (i_start) begin
            busy_d  = 1'b1;
            cnt_d   = '0;
            den_d   = i_denom;
            rem_d   = '0;
            dvd_d   = DVD_W'(1) << (DVD_W - 1);
            small_d = (i_denom < DEN_W'(128));
        end else if (busy_q) begin
            // remainder stays below den, so the difference always fits DEN_W
            if (rem_sh >= {1'b0, den_q}) begin
                rem_d = DEN_W'(rem_sh - {1'b0, den_q});
                dvd_d = {dvd_q[DVD_W-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[DEN_W-1:0];
                dvd_d = {dvd_q[DVD_W-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(RECIP_ITER - 1)) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                recip_d = small_q ? '1 : dvd_d[RECIP_W-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        den_q   <= den_d;
        rem_q   <= rem_d;
        dvd_q   <= dvd_d;
        small_q <= small_d;
        recip_q <= recip_d;
    end

    assign o_recip = recip_q;
    assign o_done  = done_q;

endmodule

// File: rtl/softmax_norm.sv
// -----------------------------------------------------------------------------
// softmax_norm
// Buffers one row of per-beat y (Q1.7) and running-max snapshots from the
// online-softmax stream. On the final beat it computes per-lane reciprocals of
// the denominator, then drains the row: each y is rescaled by
// 2^-(final_max - snapshot_max), multiplied by the reciprocal and emitted as a
// Q0.8 probability over a valid/ready handshake.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : row beats in, probabilities out (see softmax_norm_if)
//   o_busy         : high while reciprocals run or the row drains
//   o_overflow     : sticky flag for any dropped beat / stray denom_valid
// Build option: define SOFTMAX_NORM_ROUND_EN to round p half-up instead of
// truncating.
// -----------------------------------------------------------------------------
module softmax_norm
    import softmax_norm_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int LANES = LANES_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    softmax_norm_if.slave bus,
    output logic          o_busy,
    output logic          o_overflow
);

    localparam int CNT_W = $clog2(N + 1);
    localparam int AW    = $clog2(N);

    // Shift is never negative for a legal stream; a negative shift is taken as 0.
    function automatic logic [Y_W-1:0] rescale_y(input logic [Y_W-1:0] y,
                                                 input logic signed [MAX_W-1:0] snap,
                                                 input logic signed [MAX_W-1:0] fmax);
        logic signed [MAX_W:0] sh;
        sh = $signed({fmax[MAX_W-1], fmax}) - $signed({snap[MAX_W-1], snap});
        if (sh[MAX_W])            return y;
        else if (|sh[MAX_W-1:3])  return '0;
        else                      return y >> sh[2:0];
    endfunction

    function automatic logic [PROD_W:0] round_prod(input logic [PROD_W-1:0] prod);
`ifdef SOFTMAX_NORM_ROUND_EN
        return ({1'b0, prod} + (PROD_W + 1)'(1 << 14)) >> 15;
`else
        return {1'b0, prod} >> 15;
`endif
    endfunction

    function automatic logic [P_W-1:0] sat_p(input logic [PROD_W:0] v);
        return (|v[PROD_W:P_W]) ? '1 : v[P_W-1:0];
    endfunction

    function automatic logic [P_W-1:0] scale_lane(input logic [Y_W-1:0] y,
                                                  input logic [MAX_W-1:0] snap,
                                                  input logic [MAX_W-1:0] fmax,
                                                  input logic [RECIP_W-1:0] recip);
        logic [PROD_W-1:0] prod;
        prod = {{(PROD_W - Y_W){1'b0}}, rescale_y(y, snap, fmax)}
             * {{(PROD_W - RECIP_W){1'b0}}, recip};
        return sat_p(round_prod(prod));
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   row_len_q, row_len_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic [P_W*LANES-1:0] p_q, p_d;

    logic [Y_W*LANES-1:0]   y_mem_q   [N];
    logic [MAX_W*LANES-1:0] max_mem_q [N];
    logic [MAX_W*LANES-1:0] fmax_q;

    logic                 mem_we;
    logic                 close_row;
    logic                 fire;
    logic [AW-1:0]        wr_addr, rd_addr;
    logic [Y_W*LANES-1:0]   y_rd;
    logic [MAX_W*LANES-1:0] max_rd;
    logic [P_W*LANES-1:0]   p_calc;
    logic [RECIP_W-1:0]   recip [LANES];
    logic [LANES-1:0]     done_vec;

    assign wr_addr = wr_cnt_q[AW-1:0];
    assign rd_addr = rd_ptr_q[AW-1:0];
    assign y_rd    = y_mem_q[rd_addr];
    assign max_rd  = max_mem_q[rd_addr];
    assign fire    = valid_q & bus.i_ready;

    // ---- reciprocal stage: one divider per lane, all started together ----
    for (genvar l = 0; l < LANES; l++) begin : g_recip
        softmax_recip u_recip (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_start (close_row),
            .i_denom (bus.i_denom[l*DEN_W +: DEN_W]),
            .o_recip (recip[l]),
            .o_done  (done_vec[l])
        );
    end

    // ---- drain stage: rescale, multiply, round and saturate entry rd_ptr ----
    always_comb begin
        p_calc = '0;
        for (int l = 0; l < LANES; l++) begin
            p_calc[l*P_W +: P_W] = scale_lane(y_rd[l*Y_W +: Y_W],
                                              max_rd[l*MAX_W +: MAX_W],
                                              fmax_q[l*MAX_W +: MAX_W],
                                              recip[l]);
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        rd_ptr_d  = rd_ptr_q;
        row_len_d = row_len_q;
        ovf_d     = ovf_q;
        valid_d   = valid_q;
        last_d    = last_q;
        p_d       = p_q;
        mem_we    = 1'b0;
        close_row = 1'b0;
        case (state_q)
            S_FILL: begin
                if (bus.i_y_valid) begin
                    if (wr_cnt_q == CNT_W'(N)) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_we   = 1'b1;
                        wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    end
                    // A closing beat on a full buffer is dropped, but the row
                    // still closes with the N entries already stored.
                    if (bus.i_denom_valid) begin
                        close_row = 1'b1;
                        row_len_d = (wr_cnt_q == CNT_W'(N)) ? wr_cnt_q : wr_cnt_q + CNT_W'(1);
                        state_d   = S_RECIP;
                    end
                end else if (bus.i_denom_valid) begin
                    ovf_d = 1'b1;
                end
            end
            S_RECIP: begin
                if (bus.i_y_valid) ovf_d = 1'b1;
                if (&done_vec) begin
                    state_d  = S_DRAIN;
                    rd_ptr_d = '0;
                end
            end
            S_DRAIN: begin
                if (bus.i_y_valid) ovf_d = 1'b1;
                if (fire && last_q) begin
                    state_d  = S_FILL;
                    wr_cnt_d = '0;
                    valid_d  = 1'b0;
                    last_d   = 1'b0;
                end else if ((!valid_q || fire) && (rd_ptr_q < row_len_q)) begin
                    p_d      = p_calc;
                    last_d   = (rd_ptr_q == row_len_q - CNT_W'(1));
                    valid_d  = 1'b1;
                    rd_ptr_d = rd_ptr_q + CNT_W'(1);
                end else if (fire) begin
                    valid_d = 1'b0;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_FILL;
            wr_cnt_q  <= '0;
            rd_ptr_q  <= '0;
            row_len_q <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            p_q       <= '0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_ptr_q  <= rd_ptr_d;
            row_len_q <= row_len_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            p_q       <= p_d;
        end
    end

    // ---- fill stage: row buffer and final max, no reset needed ----
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            y_mem_q[wr_addr]   <= bus.i_y;
            max_mem_q[wr_addr] <= bus.i_runmax;
        end
        if (close_row) fmax_q <= bus.i_runmax;
    end

    assign bus.o_p     = p_q;
    assign bus.o_valid = valid_q;
    assign bus.o_last  = last_q;
    assign o_busy      = (state_q != S_FILL);
    assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_softmax_norm.sv
module tb_softmax_norm;

    localparam int L  = 16;
    localparam int NB = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, ovf;

    always #5 clk = ~clk;

    softmax_norm_if #(.LANES(L)) bus ();

    softmax_norm #(.N(NB), .LANES(L)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .bus        (bus),
        .o_busy     (busy),
        .o_overflow (ovf)
    );

    int n_pass  = 0;
    int n_total = 0;
    logic [128:0] exp_q [$];
    logic [128:0] exp;

    function automatic logic [7:0] model_p(input logic [7:0] y, input int sh, input int d);
        longint r, yc, prod, p;
        r = (d < 128) ? 131071 : (64'd8388608 / d);
        if (sh < 0) sh = 0;
        yc = (sh >= 8) ? 0 : (y >> sh);
        prod = yc * r;
`ifdef SOFTMAX_NORM_ROUND_EN
        p = (prod + 16384) >>> 15;
`else
        p = prod >>> 15;
`endif
        if (p > 255) p = 255;
        return p[7:0];
    endfunction

    task automatic send_beat(input logic [127:0] y, input logic [479:0] rm,
                             input logic [255:0] den, input logic dv);
        bus.i_y_valid     = 1'b1;
        bus.i_y           = y;
        bus.i_runmax      = rm;
        bus.i_denom       = den;
        bus.i_denom_valid = dv;
        @(negedge clk);
        bus.i_y_valid     = 1'b0;
        bus.i_denom_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_total++; if (bus.o_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.o_valid); else n_pass++;
        n_total++; if (bus.o_last !== 1'b0) $display("FAIL reset_last: got %b expected 0", bus.o_last); else n_pass++;
        n_total++; if (bus.o_p !== '0) $display("FAIL reset_p: got %h expected 0", bus.o_p); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovf); else n_pass++;
    endtask

    task automatic test_single();
        int cyc;
        exp_q.push_back({1'b1, {16{8'hFF}}});
        send_beat({16{8'h80}}, {16{30'd5}}, {16{16'h0080}}, 1'b1);
        n_total++; if (busy !== 1'b1) $display("FAIL single_busy: got %b expected 1", busy); else n_pass++;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 400) begin
            @(negedge clk); cyc++;
            if (bus.o_valid && bus.i_ready) begin
                exp = exp_q.pop_front();
                n_total++;
                if ({bus.o_last, bus.o_p} !== exp) $display("FAIL single: got last=%b p=%h expected last=%b p=%h", bus.o_last, bus.o_p, exp[128], exp[127:0]);
                else n_pass++;
            end
        end
        n_total++;
        if (exp_q.size() != 0) begin $display("FAIL single_timeout: %0d outstanding expected 0", exp_q.size()); exp_q.delete(); end
        else n_pass++;
        @(negedge clk);
        n_total++; if ({busy, bus.o_valid, ovf} !== 3'b000) $display("FAIL single_idle: got busy/valid/ovf=%b expected 000", {busy, bus.o_valid, ovf}); else n_pass++;
    endtask

    task automatic test_two_beats();
        int cyc;
        exp_q.push_back({1'b0, {16{8'h80}}});
        exp_q.push_back({1'b1, {16{8'h80}}});
        send_beat({16{8'h80}}, {16{30'd0}}, {16{16'h0000}}, 1'b0);
        send_beat({16{8'h80}}, {16{30'd0}}, {16{16'h0100}}, 1'b1);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 400) begin
            @(negedge clk); cyc++;
            if (bus.o_valid && bus.i_ready) begin
                exp = exp_q.pop_front();
                n_total++;
                if ({bus.o_last, bus.o_p} !== exp) $display("FAIL two_beats: got last=%b p=%h expected last=%b p=%h", bus.o_last, bus.o_p, exp[128], exp[127:0]);
                else n_pass++;
            end
        end
        n_total++;
        if (exp_q.size() != 0) begin $display("FAIL two_beats_timeout: %0d outstanding expected 0", exp_q.size()); exp_q.delete(); end
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_rescale();
        int cyc;
        exp_q.push_back({1'b0, {16{8'h33}}});
`ifdef SOFTMAX_NORM_ROUND_EN
        exp_q.push_back({1'b1, {16{8'hCD}}});
`else
        exp_q.push_back({1'b1, {16{8'hCC}}});
`endif
        send_beat({16{8'h80}}, {16{30'd0}}, {16{16'h0000}}, 1'b0);
        send_beat({16{8'h80}}, {16{30'd2}}, {16{16'h00A0}}, 1'b1);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 400) begin
            @(negedge clk); cyc++;
            if (bus.o_valid && bus.i_ready) begin
                exp = exp_q.pop_front();
                n_total++;
                if ({bus.o_last, bus.o_p} !== exp) $display("FAIL rescale: got last=%b p=%h expected last=%b p=%h", bus.o_last, bus.o_p, exp[128], exp[127:0]);
                else n_pass++;
            end
        end
        n_total++;
        if (exp_q.size() != 0) begin $display("FAIL rescale_timeout: %0d outstanding expected 0", exp_q.size()); exp_q.delete(); end
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int cyc, hs;
        bus.i_ready = 1'b0;
        exp_q.push_back({1'b0, {16{8'h80}}});
        exp_q.push_back({1'b1, {16{8'h80}}});
        send_beat({16{8'h80}}, {16{30'd0}}, {16{16'h0000}}, 1'b0);
        send_beat({16{8'h80}}, {16{30'd0}}, {16{16'h0100}}, 1'b1);
        cyc = 0;
        while (!bus.o_valid && cyc < 200) begin @(negedge clk); cyc++; end
        n_total++; if (bus.o_valid !== 1'b1) $display("FAIL bp_first_valid: got %b expected 1", bus.o_valid); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if ({bus.o_valid, bus.o_last, bus.o_p} !== {1'b1, exp_q[0]})
                $display("FAIL bp_stall%0d: got valid=%b last=%b p=%h expected valid=1 last=%b p=%h", i, bus.o_valid, bus.o_last, bus.o_p, exp_q[0][128], exp_q[0][127:0]);
            else n_pass++;
            @(negedge clk);
        end
        bus.i_ready = 1'b1;
        hs = 0;
        cyc = 0;
        while (cyc < 60) begin
            if (bus.o_valid && bus.i_ready) begin
                hs++;
                if (exp_q.size() > 0) begin
                    exp = exp_q.pop_front();
                    n_total++;
                    if ({bus.o_last, bus.o_p} !== exp) $display("FAIL bp_data: got last=%b p=%h expected last=%b p=%h", bus.o_last, bus.o_p, exp[128], exp[127:0]);
                    else n_pass++;
                end
            end
            @(negedge clk); cyc++;
        end
        n_total++; if (hs != 2) $display("FAIL bp_handshakes: got %0d expected 2", hs); else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_overflow();
        logic [7:0] ys [17][L];
        int base [L];
        int den [L];
        logic [127:0] yv;
        logic [479:0] rv;
        logic [255:0] dvec;
        logic [128:0] e;
        int cyc, got, inj;
        for (int l = 0; l < L; l++) begin
            base[l] = $urandom_range(0, 100000);
            den[l]  = (l == 0) ? 0 : (l == 1) ? 127 : (l == 2) ? 128 : $urandom_range(129, 2000);
            dvec[l*16 +: 16] = den[l][15:0];
        end
        for (int b = 0; b < 17; b++) begin
            for (int l = 0; l < L; l++) begin
                ys[b][l] = 8'($urandom_range(0, 255));
                yv[l*8 +: 8] = ys[b][l];
                rv[l*30 +: 30] = 30'(base[l] + b / 2);
            end
            if (b == NB) begin
                n_total++; if (ovf !== 1'b0) $display("FAIL ovf_before_full: got %b expected 0", ovf); else n_pass++;
            end
            send_beat(yv, rv, '0, 1'b0);
        end
        n_total++; if (ovf !== 1'b1) $display("FAIL ovf_after_full: got %b expected 1", ovf); else n_pass++;
        for (int b = 0; b < NB; b++) begin
            e = '0;
            e[128] = (b == NB - 1);
            for (int l = 0; l < L; l++) e[l*8 +: 8] = model_p(ys[b][l], 10 - b / 2, den[l]);
            exp_q.push_back(e);
        end
        for (int l = 0; l < L; l++) rv[l*30 +: 30] = 30'(base[l] + 10);
        send_beat({16{8'hFF}}, rv, dvec, 1'b1);
        n_total++; if (busy !== 1'b1) $display("FAIL ovf_row_closed: busy got %b expected 1", busy); else n_pass++;
        cyc = 0; got = 0; inj = 0;
        while (exp_q.size() > 0 && cyc < 800) begin
            @(negedge clk); cyc++;
            if (bus.o_valid && bus.i_ready) begin
                exp = exp_q.pop_front();
                got++;
                n_total++;
                if ({bus.o_last, bus.o_p} !== exp) $display("FAIL ovf_entry%0d: got last=%b p=%h expected last=%b p=%h", got - 1, bus.o_last, bus.o_p, exp[128], exp[127:0]);
                else n_pass++;
            end
            if (busy && got >= 1 && inj < 6) begin
                bus.i_y_valid = 1'b1;
                bus.i_y = {4{32'($urandom)}};
                inj++;
            end else begin
                bus.i_y_valid = 1'b0;
            end
            bus.i_ready = ($urandom_range(0, 3) != 0);
        end
        bus.i_y_valid = 1'b0;
        bus.i_ready = 1'b1;
        n_total++;
        if (exp_q.size() != 0) begin $display("FAIL ovf_timeout: %0d outstanding expected 0", exp_q.size()); exp_q.delete(); end
        else n_pass++;
        @(negedge clk);
        n_total++; if ({busy, bus.o_valid} !== 2'b00) $display("FAIL ovf_idle: got busy/valid=%b expected 00", {busy, bus.o_valid}); else n_pass++;
    endtask

    task automatic test_reset_drain();
        int cyc;
        bus.i_ready = 1'b0;
        send_beat({16{8'h80}}, {16{30'd0}}, {16{16'h0000}}, 1'b0);
        send_beat({16{8'h80}}, {16{30'd0}}, {16{16'h0100}}, 1'b1);
        cyc = 0;
        while (!bus.o_valid && cyc < 200) begin @(negedge clk); cyc++; end
        n_total++; if (bus.o_valid !== 1'b1) $display("FAIL rd_reach_drain: got %b expected 1", bus.o_valid); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if ({bus.o_valid, busy, ovf} !== 3'b000) $display("FAIL rd_abort: got valid/busy/ovf=%b expected 000", {bus.o_valid, busy, ovf}); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_ready = 1'b1;
        exp_q.delete();
        exp_q.push_back({1'b1, {16{8'h40}}});
        send_beat({16{8'h40}}, {16{30'd3}}, {16{16'h0100}}, 1'b1);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 400) begin
            @(negedge clk); cyc++;
            if (bus.o_valid && bus.i_ready) begin
                exp = exp_q.pop_front();
                n_total++;
                if ({bus.o_last, bus.o_p} !== exp) $display("FAIL rd_new_row: got last=%b p=%h expected last=%b p=%h", bus.o_last, bus.o_p, exp[128], exp[127:0]);
                else n_pass++;
            end
        end
        n_total++;
        if (exp_q.size() != 0) begin $display("FAIL rd_timeout: %0d outstanding expected 0", exp_q.size()); exp_q.delete(); end
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        bus.i_y_valid     = 1'b0;
        bus.i_y           = '0;
        bus.i_runmax      = '0;
        bus.i_denom       = '0;
        bus.i_denom_valid = 1'b0;
        bus.i_ready       = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_two_beats();
        test_rescale();
        test_backpressure();
        test_overflow();
        test_reset_drain();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
